// File: rtl/fft_bitrev_reorder_if.sv
// fft_bitrev_reorder_if: sample stream in (bit-reversed) and bin stream out (natural order).
// FFT_REORDER_INDEX_EN adds the index_o bin index signal.
interface fft_bitrev_reorder_if #(
    parameter int DATA_W = 16,
    parameter int LOG2N  = 5
);
    logic              valid_i;
    logic [DATA_W-1:0] data_in_r;
    logic [DATA_W-1:0] data_in_i;
    logic              valid_o;
    logic              frame_start_o;
    logic [DATA_W-1:0] data_out_r;
    logic [DATA_W-1:0] data_out_i;
`ifdef FFT_REORDER_INDEX_EN
    logic [LOG2N-1:0]  index_o;
    modport master (output valid_i, data_in_r, data_in_i,
                    input  valid_o, frame_start_o, data_out_r, data_out_i, index_o);
    modport slave  (input  valid_i, data_in_r, data_in_i,
                    output valid_o, frame_start_o, data_out_r, data_out_i, index_o);
`else
    modport master (output valid_i, data_in_r, data_in_i,
                    input  valid_o, frame_start_o, data_out_r, data_out_i);
    modport slave  (input  valid_i, data_in_r, data_in_i,
                    output valid_o, frame_start_o, data_out_r, data_out_i);
`endif
endinterface

// File: rtl/fft_bitrev_reorder.sv
// fft_bitrev_reorder: ping-pong buffer turning bit-reversed FFT frames into natural-order bursts.
// Define FFT_REORDER_INDEX_EN to expose the output bin index on index_o.
module fft_bitrev_reorder #(
    parameter int DATA_W = 16,
    parameter int LOG2N  = 5
) (
    input logic                 clk,
    input logic                 rst,
    fft_bitrev_reorder_if.slave bus
);
    localparam int N = 1 << LOG2N;
    typedef enum logic {IDLE, READ} state_t;
    state_t              r_state;
    logic [2*DATA_W-1:0] r_mem [2][N];
    logic [LOG2N-1:0]    r_wr_cnt, r_rd_cnt, w_wr_addr, w_rd_addr;
    logic                r_wr_bank, r_rd_bank, w_rd_bank;
    logic                w_wrap, w_start, w_emit, w_last;
    logic [1:0]          r_full;
    logic                r_valid, r_fstart;
    logic [DATA_W-1:0]   r_out_r, r_out_i;
    always_comb begin
        w_wr_addr = '0;
        for (int k = 0; k < LOG2N; k++) w_wr_addr[k] = r_wr_cnt[LOG2N-1-k];
    end
    assign w_wrap    = bus.valid_i && (&r_wr_cnt);
    assign w_start   = (r_state == IDLE) && (|r_full);
    assign w_emit    = w_start || (r_state == READ);
    assign w_last    = (r_state == READ) && (&r_rd_cnt);
    // Leaving IDLE emits bin 0 on the same edge, so no bubble between bursts.
    assign w_rd_bank = (r_state == IDLE) ? !r_full[0] : r_rd_bank;
    assign w_rd_addr = (r_state == IDLE) ? '0 : r_rd_cnt;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_cnt  <= '0;
            r_wr_bank <= 1'b0;
        end else if (bus.valid_i) begin
            r_wr_cnt  <= r_wr_cnt + LOG2N'(1);
            r_wr_bank <= w_wrap ? !r_wr_bank : r_wr_bank;
        end
    end
    always_ff @(posedge clk) begin
        if (bus.valid_i) r_mem[r_wr_bank][w_wr_addr] <= {bus.data_in_r, bus.data_in_i};
    end
`ifdef FFT_REORDER_INDEX_EN
    logic [LOG2N-1:0] r_index;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_index <= '0;
        else if (w_emit) r_index <= w_rd_addr;
    end
    assign bus.index_o = r_index;
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_rd_bank <= 1'b0;
            r_rd_cnt  <= '0;
            r_full    <= '0;
            r_valid   <= 1'b0;
            r_fstart  <= 1'b0;
            r_out_r   <= '0;
            r_out_i   <= '0;
        end else begin
            r_valid  <= w_emit;
            r_fstart <= w_start || (r_state == READ && r_rd_cnt == '0);
            if (w_emit) {r_out_r, r_out_i} <= r_mem[w_rd_bank][w_rd_addr];
            if (w_last) r_full[r_rd_bank] <= 1'b0;
            if (w_wrap) r_full[r_wr_bank] <= 1'b1;
            if (w_start) begin
                r_state   <= READ;
                r_rd_bank <= w_rd_bank;
                r_rd_cnt  <= LOG2N'(1);
            end else if (r_state == READ) begin
                r_rd_cnt <= r_rd_cnt + LOG2N'(1);
                if (w_last) begin
                    r_state   <= r_full[!r_rd_bank] ? READ : IDLE;
                    r_rd_bank <= !r_rd_bank;
                end
            end
        end
    end
    assign bus.valid_o       = r_valid;
    assign bus.frame_start_o = r_fstart;
    assign bus.data_out_r    = r_out_r;
    assign bus.data_out_i    = r_out_i;
endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// tb_fft_bitrev_reorder: directed checks of bit-reversed to natural-order frame reordering.
module tb_fft_bitrev_reorder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_cmp = 0;
    int n_bad = 0;
    fft_bitrev_reorder_if #(.DATA_W(16), .LOG2N(5)) bus ();
    fft_bitrev_reorder #(.DATA_W(16), .LOG2N(5)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    function automatic int br5(input int k);
        return {27'd0, k[0], k[1], k[2], k[3], k[4]};
    endfunction
    function automatic int w16(input int v);
        return v & 32'hFFFF;
    endfunction
    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic cyc(input bit v, input int r);
        bus.valid_i   = v;
        bus.data_in_r = 16'(r);
        bus.data_in_i = 16'(-r);
        @(posedge clk);
        #1;
        bus.valid_i = 1'b0;
    endtask
    task automatic quiet(input string tag, input int n);
        int c = 0;
        for (int j = 0; j < n; j++) begin
            cyc(1'b0, 0);
            if (bus.valid_o) c++;
        end
        chk(tag, c, 0);
    endtask
    task automatic out_chk(input string tag, input int k, input int fs, input int val);
        chk($sformatf("%s_valid[%0d]", tag, k), int'(bus.valid_o), 1);
        chk($sformatf("%s_fstart[%0d]", tag, k), int'(bus.frame_start_o), fs);
        chk($sformatf("%s_re[%0d]", tag, k), int'(bus.data_out_r), w16(val));
        chk($sformatf("%s_im[%0d]", tag, k), int'(bus.data_out_i), w16(-val));
    endtask
    task automatic burst(input string tag, input int base, input int len);
        for (int k = 0; k < len; k++) begin
            cyc(1'b0, 0);
            out_chk(tag, k, int'(k == 0), base + br5(k));
`ifdef FFT_REORDER_INDEX_EN
            chk($sformatf("%s_idx[%0d]", tag, k), int'(bus.index_o), k);
`endif
        end
    endtask
    task automatic send(input int base);
        for (int n = 0; n < 32; n++) cyc(1'b1, base + n);
    endtask
    // A completed bank must be drained before the writer comes back to it.
    always @(posedge clk) begin
        if (!rst && bus.valid_i) begin
            n_cmp++;
            assert (!dut.r_full[dut.r_wr_bank]) else begin
                n_bad++;
                $error("FAIL write_into_full_bank observed=1 expected=0");
            end
        end
    end
    initial begin
        bus.valid_i   = 1'b0;
        bus.data_in_r = '0;
        bus.data_in_i = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", int'(bus.valid_o), 0);
        chk("rst_fstart", int'(bus.frame_start_o), 0);
        chk("rst_re", int'(bus.data_out_r), 0);
        chk("rst_im", int'(bus.data_out_i), 0);
`ifdef FFT_REORDER_INDEX_EN
        chk("rst_idx", int'(bus.index_o), 0);
`endif
        bus.valid_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        bus.valid_i = 1'b0;
        rst = 1'b0;
        quiet("rst_quiet", 40);
        // Single continuous frame.
        send(0);
        chk("single_latency", int'(bus.valid_o), 0);
        burst("single", 0, 32);
        cyc(1'b0, 0);
        chk("single_after_valid", int'(bus.valid_o), 0);
        chk("single_after_fstart", int'(bus.frame_start_o), 0);
        chk("single_hold_re", int'(bus.data_out_r), 31);
        chk("single_hold_im", int'(bus.data_out_i), w16(-31));
`ifdef FFT_REORDER_INDEX_EN
        chk("single_hold_idx", int'(bus.index_o), 31);
`endif
        // Two back-to-back frames.
        for (int c = 0; c < 96; c++) begin
            cyc(c < 64, c < 32 ? c : 100 + c - 32);
            if (c < 32) chk($sformatf("b2b_pre[%0d]", c), int'(bus.valid_o), 0);
            else out_chk("b2b", c - 32, int'((c - 32) % 32 == 0),
                         (c < 64 ? 0 : 100) + br5((c - 32) % 32));
        end
        cyc(1'b0, 0);
        chk("b2b_after_valid", int'(bus.valid_o), 0);
        // Input gapped to every third cycle.
        for (int n = 0; n < 32; n++) begin
            cyc(1'b1, 300 + n);
            if (n < 31) begin
                cyc(1'b0, 0);
                cyc(1'b0, 0);
                chk($sformatf("gap_idle[%0d]", n), int'(bus.valid_o), 0);
            end
        end
        chk("gap_latency", int'(bus.valid_o), 0);
        burst("gap", 300, 32);
        cyc(1'b0, 0);
        chk("gap_after_valid", int'(bus.valid_o), 0);
        // Partial frame discarded by a reset pulse between edges.
        for (int n = 0; n < 10; n++) cyc(1'b1, 7 + n);
        rst = 1'b1;
        #2;
        rst = 1'b0;
        send(200);
        chk("mid_latency", int'(bus.valid_o), 0);
        burst("mid", 200, 32);
        quiet("mid_one_burst", 40);
        // Asynchronous reset in the middle of a burst.
        send(200);
        burst("cut", 200, 10);
        rst = 1'b1;
        #1;
        chk("cut_valid", int'(bus.valid_o), 0);
        chk("cut_fstart", int'(bus.frame_start_o), 0);
        chk("cut_re", int'(bus.data_out_r), 0);
        chk("cut_im", int'(bus.data_out_i), 0);
`ifdef FFT_REORDER_INDEX_EN
        chk("cut_idx", int'(bus.index_o), 0);
`endif
        #1;
        rst = 1'b0;
        quiet("cut_quiet", 40);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
